// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_e;
    localparam int INSTR_W = 16;
    localparam int PC_STEP = 2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: DEPTH-entry synchronous prefetch FIFO; flush wins over push and pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & ~full_o & ~flush_i & reset;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= do_push ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= do_pop ? rptr_q + AW'(1) : rptr_q;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: handshaked sequential fetch engine with a prefetch FIFO for the multicycle core.
// Define IFU_BYPASS_EN to forward ack data straight to the core when the FIFO is empty.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_W + ADDR_W;
    localparam logic [CW:0] DEPTH_N = (CW+1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic              req_q, req_d;
    logic              accept, push, pop, fifo_pop, empty, full;
    logic [CW-1:0]     count;
    logic [CW:0]       count_after;
    logic [EW-1:0]     head;

    assign accept      = (state_q == WAIT) & imem_ack & ~redirect;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign fifo_pop    = pop & ~empty;
    assign count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(fifo_pop);
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass      = empty & accept;
    assign push        = accept & ~(bypass & instr_ready);
    assign instr_valid = ~empty | bypass;
    assign instr       = ~empty ? head[EW-1:ADDR_W] : bypass ? imem_rdata : '0;
    assign instr_pc    = ~empty ? head[ADDR_W-1:0] : bypass ? fetch_pc_q : '0;
`else
    assign push        = accept;
    assign instr_valid = ~empty;
    assign instr       = empty ? '0 : head[EW-1:ADDR_W];
    assign instr_pc    = empty ? '0 : head[ADDR_W-1:0];
`endif

    ifu_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem_rdata, fetch_pc_q}),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    // Redirect beats everything; an in-flight request without its ack must still be drained.
    always_comb begin
        fetch_pc_d = redirect ? (redirect_pc & ~(ADDR_W'(1)))
                   : accept   ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
        if (redirect)              state_d = (state_q == IDLE || imem_ack) ? IDLE : DISCARD;
        else if (state_q == IDLE)  state_d = full ? IDLE : WAIT;
        else if (state_q == WAIT)  state_d = !imem_ack ? WAIT : (count_after < DEPTH_N) ? WAIT : IDLE;
        else                       state_d = imem_ack ? IDLE : DISCARD;
        addr_d = (state_d == WAIT) ? fetch_pc_d : addr_q;
        req_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench; memory model returns A000+addr and a stream model
// predicts the in-order pc/instruction sequence the core must see.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ack, redirect, instr_valid, instr_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    int          errors = 0, checks = 0, cyc = 0, acks = 0, lat_cfg = 0, lat_left = 0;
    bit          mem_auto = 0, mem_rand = 0, prev_redir = 0, prev_hold = 0;
    logic [15:0] exp_pc = 16'h0000, prev_addr = 16'h0000;
    int          ack_cyc[$], pop_cyc[$];
    logic [15:0] pc_log[$];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    function automatic int next_lat();
        return mem_rand ? int'($urandom_range(0, 3)) : lat_cfg;
    endfunction

    // One clock: drive memory, check stream/protocol, advance to 1 time unit after the edge.
    task automatic tick();
        if (mem_auto) begin
            if (!imem_req) begin
                imem_ack = 1'b0;
                lat_left = next_lat();
            end else if (lat_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = data_of(imem_addr);
                lat_left   = next_lat();
            end else begin
                imem_ack = 1'b0;
                lat_left--;
            end
        end
        if (imem_ack && imem_req && reset) begin
            acks++;
            ack_cyc.push_back(cyc);
        end
        #1;
        if (prev_redir) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_redirect: instr_valid=%b want 0 (cycle %0d)", instr_valid, cyc);
            end
        end
        if (prev_hold) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: req=%b addr=%h want req=1 addr=%h (cycle %0d)", imem_req, imem_addr, prev_addr, cyc);
            end
        end
        if (!reset) exp_pc = 16'h0000;
        else if (redirect) exp_pc = redirect_pc & 16'hFFFE;
        else if (instr_valid && instr_ready) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== data_of(exp_pc)) begin
                errors++;
                $display("FAIL pop: got pc=%h instr=%h want pc=%h instr=%h (cycle %0d)", instr_pc, instr, exp_pc, data_of(exp_pc), cyc);
            end
            pc_log.push_back(instr_pc);
            pop_cyc.push_back(cyc);
            exp_pc = exp_pc + 16'd2;
        end
        prev_redir = reset && redirect;
        prev_hold  = reset && imem_req && !imem_ack;
        prev_addr  = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; redirect = 1'b0;
        redirect_pc = 16'h0; instr_ready = 1'b0; mem_auto = 1'b0; mem_rand = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        acks = 0;
        ack_cyc.delete(); pop_cyc.delete(); pc_log.delete();
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        for (int i = 0; i < budget && pc_log.size() < n; i++) tick();
        if (pc_log.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pops want %0d", name, pc_log.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        lat_cfg = 0; mem_auto = 1'b1;
        repeat (8) tick();
        reset = 1'b0; mem_auto = 1'b0; imem_ack = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        checks++;
        if (instr !== 16'h0 || instr_pc !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h pc=%h want 0000/0000", instr, instr_pc);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        lat_cfg = 2; instr_ready = 1'b1; mem_auto = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1/0000", imem_req, imem_addr);
        end
        wait_pops(3, 40, "seq");
        if (pc_log.size() >= 3 && ack_cyc.size() >= 1) begin
            checks++;
            if (pop_cyc[0] - ack_cyc[0] != (BYP ? 0 : 1)) begin
                errors++;
                $display("FAIL seq_latency: pop-ack=%0d want %0d", pop_cyc[0] - ack_cyc[0], BYP ? 0 : 1);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != lat_cfg + 1) begin
                    errors++;
                    $display("FAIL seq_gap%0d: gap=%0d want %0d", i, pop_cyc[i] - pop_cyc[i-1], lat_cfg + 1);
                end
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        lat_cfg = 0; mem_auto = 1'b1;
        repeat (30) tick();
        checks++;
        if (acks != DEPTH || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fill_stop: acks=%0d req=%b want %0d/0", acks, imem_req, DEPTH);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'hA000) begin
            errors++;
            $display("FAIL fill_head: valid=%b pc=%h instr=%h want 1/0000/A000", instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        wait_pops(6, 30, "fill");
        if (pc_log.size() >= 6) begin
            checks++;
            if (pc_log[5] !== 16'h000A) begin
                errors++;
                $display("FAIL fill_order: sixth pc=%h want 000A", pc_log[5]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL discard_hold: req=%b addr=%h want 1/0000", imem_req, imem_addr);
        end
        tick();
        tick();
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_drop: req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL redirect_addr: req=%b addr=%h want 1/0040", imem_req, imem_addr);
        end
        lat_cfg = 1; lat_left = 1; mem_auto = 1'b1;
        wait_pops(1, 20, "redir_wait");
        if (pc_log.size() >= 1) begin
            checks++;
            if (pc_log[0] !== 16'h0040) begin
                errors++;
                $display("FAIL redir_first: pc=%h want 0040", pc_log[0]);
            end
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        lat_cfg = 0; mem_auto = 1'b1;
        for (int i = 0; i < 20 && acks < 2; i++) tick();
        mem_auto = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rap_setup: req=%b valid=%b want 1/1", imem_req, instr_valid);
        end
        imem_ack = 1'b1; imem_rdata = data_of(imem_addr);
        redirect = 1'b1; redirect_pc = 16'h1234; instr_ready = 1'b1;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rap_flush: req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL rap_addr: req=%b addr=%h want 1/1234", imem_req, imem_addr);
        end
        mem_auto = 1'b1;
        wait_pops(1, 20, "rap");
        if (pc_log.size() >= 1) begin
            checks++;
            if (pc_log[0] !== 16'h1234) begin
                errors++;
                $display("FAIL rap_first: pc=%h want 1234", pc_log[0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [3];
        want[0] = 16'hFFFC; want[1] = 16'hFFFE; want[2] = 16'h0000;
        do_reset();
        mem_rand = 1'b1; instr_ready = 1'b1; mem_auto = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        pc_log.delete();
        wait_pops(3, 60, "wrap");
        for (int i = 0; i < 3 && i < pc_log.size(); i++) begin
            checks++;
            if (pc_log[i] !== want[i]) begin
                errors++;
                $display("FAIL wrap_pc%0d: pc=%h want %h", i, pc_log[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_req: req=%b want 0", imem_req);
        end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stray_ack: req=%b addr=%h valid=%b want 1/0000/0", imem_req, imem_addr, instr_valid);
        end
        imem_ack = 1'b1; imem_rdata = data_of(16'h0000); instr_ready = 1'b1;
        #1;
        checks++;
        if (instr_valid !== BYP) begin
            errors++;
            $display("FAIL bypass_valid: valid=%b want %b in ack cycle", instr_valid, BYP);
        end
        tick();
        imem_ack = 1'b0;
        lat_cfg = 1; lat_left = 1; mem_auto = 1'b1;
        wait_pops(2, 30, "rst_wait");
        if (pc_log.size() >= 2) begin
            checks++;
            if (pc_log[0] !== 16'h0000 || pc_log[1] !== 16'h0002) begin
                errors++;
                $display("FAIL rst_wait_order: pcs=%h,%h want 0000,0002", pc_log[0], pc_log[1]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        mem_rand = 1'b1; mem_auto = 1'b1;
        repeat (400) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = !redirect && ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        checks++;
        if (pc_log.size() < 40) begin
            errors++;
            $display("FAIL random_progress: pops=%0d want >=40", pc_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the 4-state multicycle core (IF&ID, ALU, MEM, WB).
- Replaces the combinational instruction-memory read with a handshaked fetch engine and a small prefetch FIFO.
- Fetches sequential 16-bit instructions from a slow instruction memory ahead of the core and presents them with a valid/ready pair.
- The core pops one instruction per IF&ID state; a taken BEQ or JAL redirects the fetch stream and flushes the FIFO.

Parameters:
- ADDR_W, 16, width of the instruction address and PC.
- DATA_W, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  ADDR_W  byte address of the fetch; stable while imem_req=1.
- imem_ack  in  1  single-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  DATA_W  returned instruction.
- redirect  in  1  one-cycle pulse from the core on taken branch or jump.
- redirect_pc  in  ADDR_W  new fetch address; bit 0 is ignored and forced to 0.
- instr_valid  out  1  FIFO head is valid.
- instr  out  DATA_W  FIFO head instruction.
- instr_pc  out  ADDR_W  address of the FIFO head instruction.
- instr_ready  in  1  core accepts the head (asserted in IF&ID).

Behaviour:
- Reset (reset=0 at posedge):
  - fetch_pc=RESET_PC, state=IDLE, FIFO count=0, pointers=0.
  - imem_req=0, instr_valid=0; instr and instr_pc are don't-care (driven 0).
  - Any outstanding request is abandoned. An imem_ack that arrives while in IDLE is ignored.
- FSM states:
  - IDLE: imem_req=0. Go to WAIT when count+0 < DEPTH and redirect=0; imem_req rises the next cycle.
  - WAIT: imem_req=1, imem_addr=fetch_pc. On imem_ack, push {imem_rdata, fetch_pc} and set fetch_pc+=2. Then return to IDLE, or stay in WAIT with the new address if count+1 < DEPTH after this cycle's push/pop.
  - DISCARD: imem_req=1, imem_addr=the old address. Wait for imem_ack, drop the data, go to IDLE.
- At most one request is outstanding. Space check: count + (state==WAIT) <= DEPTH.
- Pop: when instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged; push into a full FIFO is impossible by construction.
- Latency:
  - Ack-cycle data becomes the FIFO head on the next cycle (instr_valid=1 one cycle after imem_ack when the FIFO was empty).
  - Memory round trip is not bounded by this block.
- Redirect (highest priority):
  - Same cycle: count:=0, pointers reset, fetch_pc:={redirect_pc[15:1],0}; any pop that cycle is discarded.
  - If in WAIT with no ack this cycle, go to DISCARD.
  - If ack arrives in the redirect cycle, the data is dropped and the state goes to IDLE.
  - If redirect occurs in DISCARD, only fetch_pc is updated.
  - instr_valid=0 in the cycle after redirect.
- Wrap-around: fetch_pc 16'hFFFE+2 -> 16'h0000, no flag.
- imem_addr and imem_req are registered; there is no combinational path from imem_ack to imem_req.

Optional Feature:
- Macro: IFU_BYPASS_EN.
- Defined: when the FIFO is empty, imem_ack=1 and no redirect, imem_rdata/fetch_pc are driven combinationally onto instr/instr_pc with instr_valid=1.
  - If instr_ready=1 that cycle, the entry is consumed and not written.
  - Otherwise it is written as usual.
- Undefined: outputs come only from the FIFO head (fully registered; one extra cycle of latency).

Decomposition:
- Package ifu_pkg:
  - fetch state enum {IDLE, WAIT, DISCARD}
  - INSTR_W=16
  - PC_STEP=2
  - default RESET_PC
- Sub-module ifu_fifo: synchronous FIFO (DEPTH x (DATA_W+ADDR_W)) with push, pop, flush, count, empty, full. Flush has priority over push and pop.

Test Plan:
- Reset release, memory acks 2 cycles after req with data 16'hA000+addr, instr_ready=1 -> instr/instr_pc sequence (A000,0000),(A002,0002),(A004,0004), no gaps beyond the memory latency.
- instr_ready=0, immediate acks -> exactly DEPTH=4 acks accepted, then imem_req stays 0. Release ready -> pops resume from pc 0000 in order.
- Redirect to 16'h0041 while in WAIT, ack 3 cycles later -> ack data dropped, next imem_addr=16'h0040, FIFO empty the cycle after redirect.
- Redirect in the same cycle as imem_ack and an instr_ready pop -> ack data dropped, count=0, next request at redirect_pc.
- redirect_pc=16'hFFFC -> fetched addresses FFFC, FFFE, 0000, with correct instr_pc.
- reset=0 asserted in WAIT, then an ack arrives -> ack ignored, first request after release is at RESET_PC; with IFU_BYPASS_EN, an empty-FIFO ack with ready=1 gives instr_valid in the same cycle.
